// File: rtl/osc_ker_clk_req_ctrl.sv
// ---------------------------------------------------------------------------
// osc_ker_clk_req_ctrl
//
// Oscillator-side handler for kernel-clock requests from the per-peripheral
// clock/reset controllers. It merges all requests with the software
// oscillator enable and sequences the analog oscillator enable through
// start-up, ready detection, keep-alive hold and shutdown. Each requester is
// acknowledged only while the oscillator is confirmed ready.
//
// Optional build macro:
//   OSC_KER_REQ_SYNC_EN  when defined, ker_clk_req (per bit) and osc_rdy each
//                        pass through a 2-flop synchroniser. This adds two
//                        cycles to every input-to-output latency.
//                        rcc_osc_on and err_clr are never synchronised.
//
// Ports:
//   i_clk            in   RCC control clock
//   sys_rst          in   synchronous active-high reset
//   ker_clk_req      in   [REQ_NUM] per-peripheral kernel clock requests
//   rcc_osc_on       in   software oscillator enable
//   osc_rdy          in   ready flag from the analog oscillator
//   err_clr          in   single-cycle pulse, clears osc_startup_err
//   osc_en           out  oscillator enable to analog (registered)
//   osc_ker_rdy      out  oscillator usable: state ON or HOLD (registered)
//   ker_clk_ack      out  [REQ_NUM] per-requester acknowledge (registered)
//   osc_startup_err  out  sticky start-up timeout flag (registered)
//
// Request/acknowledge handshake: level based. A requester holds
// ker_clk_req[i] high for as long as it needs the kernel clock; ker_clk_ack[i]
// is high only while the request is seen and the oscillator is in ON. The ack
// drops one cycle after the request drops, or together with the ready loss.
// ---------------------------------------------------------------------------
module osc_ker_clk_req_ctrl #(
  parameter int REQ_NUM         = 4,
  parameter int STARTUP_TIMEOUT = 64,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic               i_clk,
  input  logic               sys_rst,
  input  logic [REQ_NUM-1:0] ker_clk_req,
  input  logic               rcc_osc_on,
  input  logic               osc_rdy,
  input  logic               err_clr,
  output logic               osc_en,
  output logic               osc_ker_rdy,
  output logic [REQ_NUM-1:0] ker_clk_ack,
  output logic               osc_startup_err
);

  localparam int CNT_MAX = (STARTUP_TIMEOUT > HOLD_CYCLES) ? STARTUP_TIMEOUT : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TMO_LOAD  = CW'(STARTUP_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ON       = 3'd2,
    S_HOLD     = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          err_set;

  logic [REQ_NUM-1:0] req_s;
  logic               rdy_s;
  logic               demand;

`ifdef OSC_KER_REQ_SYNC_EN
  logic [REQ_NUM-1:0] req_meta;
  logic               rdy_meta;

  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      req_meta <= '0;
      req_s    <= '0;
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      req_meta <= ker_clk_req;
      req_s    <= req_meta;
      rdy_meta <= osc_rdy;
      rdy_s    <= rdy_meta;
    end
  end
`else
  assign req_s = ker_clk_req;
  assign rdy_s = osc_rdy;
`endif

  assign demand = (|req_s) || rcc_osc_on;

  // One shared counter: start-up timeout in WAIT_RDY, keep-alive in HOLD.
  // It is only decremented when non-zero, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      S_OFF: begin
        // A still-running oscillator (rdy high) must stop before restart.
        if (demand && !rdy_s) begin
          state_nxt = S_WAIT_RDY;
          cnt_nxt   = TMO_LOAD;
        end
      end
      S_WAIT_RDY: begin
        // Ready has priority over a simultaneous timeout expiry.
        if (rdy_s) begin
          state_nxt = S_ON;
        end else if (cnt == '0) begin
          state_nxt = S_FAIL;
          err_set   = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_ON: begin
        if (!rdy_s) begin
          state_nxt = S_WAIT_RDY;
          cnt_nxt   = TMO_LOAD;
        end else if (!demand) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        // New demand beats keep-alive expiry.
        if (demand) begin
          state_nxt = S_ON;
        end else if (!rdy_s || (cnt == '0)) begin
          state_nxt = S_OFF;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_FAIL: begin
        // No retry until all demand has been withdrawn.
        if (!demand) begin
          state_nxt = S_OFF;
        end
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      state           <= S_OFF;
      cnt             <= '0;
      osc_en          <= 1'b0;
      osc_ker_rdy     <= 1'b0;
      ker_clk_ack     <= '0;
      osc_startup_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      osc_en          <= (state_nxt == S_WAIT_RDY) || (state_nxt == S_ON) ||
                         (state_nxt == S_HOLD);
      osc_ker_rdy     <= (state_nxt == S_ON) || (state_nxt == S_HOLD);
      ker_clk_ack     <= (state_nxt == S_ON) ? req_s : '0;
      // Set wins over a same-cycle clear.
      if (err_set) begin
        osc_startup_err <= 1'b1;
      end else if (err_clr) begin
        osc_startup_err <= 1'b0;
      end
    end
  end

endmodule
